// File: rtl/fsmd_count_direction_decoder.sv
// -----------------------------------------------------------------------------
// fsmd_count_direction_decoder
//   Receive-side checker for an up/down counter. Watches a sampled count bus,
//   recovers the count direction and flags holds, reversals, wrap-arounds and
//   illegal steps. It also tracks the current monotonic run length and a total
//   illegal-step count.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   count_in   observed counter value (WIDTH bits)
//   sample_en  count_in is valid this cycle
//   up         recovered direction (1=up), meaningful while dir_valid=1
//   dir_valid  direction locked
//   hold       pulse: sample equal to the previous sample
//   rev        pulse: direction reversed
//   wrap       pulse: legal step crossed max<->0
//   step_err   pulse: illegal step
//   run_len    consecutive same-direction steps, saturating (RUN_W bits)
//   err_cnt    illegal steps since reset, saturating (RUN_W bits)
// -----------------------------------------------------------------------------
module fsmd_count_direction_decoder #(
    parameter int WIDTH = 4,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             sample_en,
    output logic             up,
    output logic             dir_valid,
    output logic             hold,
    output logic             rev,
    output logic             wrap,
    output logic             step_err,
    output logic [RUN_W-1:0] run_len,
    output logic [RUN_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             up_q, up_d;
    logic             dv_q, dv_d;
    logic             hold_q, hold_d;
    logic             rev_q, rev_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] ecnt_q, ecnt_d;

    // Step classification: modular difference against the previous sample.
    logic [WIDTH-1:0] delta;
    logic             is_up, is_dn, is_hold, is_step, wrap_step;

    always_comb begin
        delta     = count_in - prev_q;
        is_up     = (delta == CNT_ONE);
        is_dn     = (delta == CNT_MAX);
        is_hold   = (delta == '0);
        is_step   = is_up | is_dn;
        // A legal step that crosses the max<->0 boundary in either direction.
        wrap_step = (is_up && prev_q == CNT_MAX && count_in == '0) ||
                    (is_dn && prev_q == '0 && count_in == CNT_MAX);
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        up_d    = up_q;
        dv_d    = dv_q;
        run_d   = run_q;
        ecnt_d  = ecnt_q;
        // Event outputs are pulses: cleared unless this sample raises them.
        hold_d  = 1'b0;
        rev_d   = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;

        if (sample_en) begin
            prev_d = count_in;
            unique case (state_q)
                IDLE: begin
                    // First sample only establishes the reference value.
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (is_step) begin
                        up_d    = is_up;
                        dv_d    = 1'b1;
                        run_d   = RUN_ONE;
                        wrap_d  = wrap_step;
                        state_d = TRACK;
                    end else if (is_hold) begin
                        hold_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (ecnt_q != RUN_MAX) ecnt_d = ecnt_q + RUN_ONE;
                    end
                end
                TRACK: begin
                    if (is_step) begin
                        wrap_d = wrap_step;
                        if (is_up == up_q) begin
                            if (run_q != RUN_MAX) run_d = run_q + RUN_ONE;
                        end else begin
                            up_d  = is_up;
                            rev_d = 1'b1;
                            run_d = RUN_ONE;
                        end
                    end else if (is_hold) begin
                        hold_d = 1'b1;
                    end else begin
                        // Lose lock; up keeps its stale value.
                        err_d   = 1'b1;
                        if (ecnt_q != RUN_MAX) ecnt_d = ecnt_q + RUN_ONE;
                        dv_d    = 1'b0;
                        run_d   = '0;
                        state_d = ACQUIRE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            up_q    <= 1'b0;
            dv_q    <= 1'b0;
            hold_q  <= 1'b0;
            rev_q   <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            up_q    <= up_d;
            dv_q    <= dv_d;
            hold_q  <= hold_d;
            rev_q   <= rev_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            run_q   <= run_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign up        = up_q;
    assign dir_valid = dv_q;
    assign hold      = hold_q;
    assign rev       = rev_q;
    assign wrap      = wrap_q;
    assign step_err  = err_q;
    assign run_len   = run_q;
    assign err_cnt   = ecnt_q;

endmodule
